// File: rtl/control_niveles_cubos.sv
// -----------------------------------------------------------------------------
// control_niveles_cubos
// Game-flow controller for the basket game. Runs NUM_NIVELES timed play
// lapses separated by a rest gap of CICLOS_DESCANSO cycles, with pause/resume
// and abort. It starts the lapse timer, enables cube spawning and publishes the
// current level index used for speed selection.
//
// Ports
//   clk              clock, all logic on posedge
//   reset            synchronous, active-high
//   start            level, begins a game while idle
//   pausa            level, requests a pause while a lapse is running
//   abortar          level, ends the game from any non-idle state
//   fin_lapso        one-cycle pulse from the lapse timer: lapse expired
//   activar_timer    registered pulse, first cycle of every new lapse
//   congelar_timer   high while paused, timer holds its count
//   habilitar_cubos  high while a lapse is running
//   nivel            current level index, 0-based
//   juego_terminado  one-cycle pulse when the game ends (normal or abort)
// -----------------------------------------------------------------------------
module control_niveles_cubos #(
  parameter int NUM_NIVELES     = 4,
  parameter int ANCHO_NIVEL     = 2,
  parameter int CICLOS_DESCANSO = 2,
  parameter int ANCHO_DESCANSO  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pausa,
  input  logic                   abortar,
  input  logic                   fin_lapso,
  output logic                   activar_timer,
  output logic                   congelar_timer,
  output logic                   habilitar_cubos,
  output logic [ANCHO_NIVEL-1:0] nivel,
  output logic                   juego_terminado
);

  typedef enum logic [2:0] {
    INICIO   = 3'd0,
    LAPSO    = 3'd1,
    PAUSA    = 3'd2,
    DESCANSO = 3'd3,
    FINAL    = 3'd4
  } estado_t;

  localparam logic [ANCHO_NIVEL-1:0]    ULTIMO_NIVEL = ANCHO_NIVEL'(NUM_NIVELES - 1);
  localparam logic [ANCHO_NIVEL-1:0]    UNO_NIVEL    = ANCHO_NIVEL'(1);
  localparam logic [ANCHO_DESCANSO-1:0] ULTIMO_DESC  = ANCHO_DESCANSO'(CICLOS_DESCANSO - 1);
  localparam logic [ANCHO_DESCANSO-1:0] UNO_DESC     = ANCHO_DESCANSO'(1);

  estado_t                   estado_q, estado_d;
  logic [ANCHO_NIVEL-1:0]    nivel_q, nivel_d;
  logic [ANCHO_DESCANSO-1:0] desc_q, desc_d;
  logic                      pend_q, pend_d;
  logic                      act_q, act_d;
  // Lapse expiry taken this cycle, either live from LAPSO or deferred from PAUSA.
  logic                      vencer;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= INICIO;
      nivel_q  <= '0;
      desc_q   <= '0;
      pend_q   <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      nivel_q  <= nivel_d;
      desc_q   <= desc_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    nivel_d  = nivel_q;
    desc_d   = desc_q;
    pend_d   = pend_q;
    act_d    = 1'b0;
    vencer   = 1'b0;

    case (estado_q)
      INICIO: begin
        if (start) begin
          estado_d = LAPSO;
          nivel_d  = '0;
          act_d    = 1'b1;
        end
      end
      LAPSO: begin
        if (abortar) begin
          estado_d = FINAL;
        end else if (fin_lapso) begin
          vencer = 1'b1;
        end else if (pausa) begin
          estado_d = PAUSA;
        end
      end
      PAUSA: begin
        if (abortar) begin
          estado_d = FINAL;
          pend_d   = 1'b0;
        end else begin
          if (fin_lapso) begin
            pend_d = 1'b1;
          end
          // An expiry that arrives in the very release cycle counts as pending.
          if (!pausa) begin
            if (pend_q || fin_lapso) begin
              pend_d = 1'b0;
              vencer = 1'b1;
            end else begin
              estado_d = LAPSO;
            end
          end
        end
      end
      DESCANSO: begin
        if (abortar) begin
          estado_d = FINAL;
        end else if (desc_q == ULTIMO_DESC) begin
          estado_d = LAPSO;
          act_d    = 1'b1;
        end else begin
          desc_d = desc_q + UNO_DESC;
        end
      end
      FINAL: begin
        estado_d = INICIO;
        nivel_d  = '0;
      end
      default: begin
        estado_d = INICIO;
        nivel_d  = '0;
        desc_d   = '0;
        pend_d   = 1'b0;
      end
    endcase

    if (vencer) begin
      if (nivel_q == ULTIMO_NIVEL) begin
        estado_d = FINAL;
      end else begin
        estado_d = DESCANSO;
        nivel_d  = nivel_q + UNO_NIVEL;
        desc_d   = '0;
      end
    end
  end

  assign activar_timer   = act_q;
  assign congelar_timer  = (estado_q == PAUSA);
  assign habilitar_cubos = (estado_q == LAPSO);
  assign juego_terminado = (estado_q == FINAL);
  assign nivel           = nivel_q;

endmodule
